cm_sketch_pipelined: RTL
========================

// Module: cm_sketch_pipelined
// PURPOSE
//  Count-min sketch for address-frequency tracking; successor to the fixed 4-row engine.
//  Depth, width and counter size are parametrised. Accepts one request per cycle through a 3-stage pipeline with write forwarding.
//  Per-request update or query-only mode, saturating counters, and a full sequential clear sweep.
//  Sits between the address monitor (producer) and the hot-page selector (consumer).
// PARAMETERS
//  W          4096  counters per row; power of 2, >=4
//  NUM_HASH   4     rows / hash functions, 1..8
//  ADDR_SIZE  22    tracked address width, <=32
//  CNT_SIZE   32    counter width, >=2
//  HASH_SIZE  $clog2(W) localparam, row index width
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous active-high reset
//  input_valid    in   1          request valid
//  input_addr     in   ADDR_SIZE  address to count or query
//  input_query    in   1          1 = estimate only (no increment), 0 = increment then estimate
//  input_ready    out  1          request accepted when input_valid & input_ready
//  clear_req      in   1          1-cycle pulse: zero all counters
//  clear_busy     out  1          high while draining or sweeping
//  output_valid   out  1          1-cycle result pulse; no backpressure
//  output_addr    out  ADDR_SIZE  address of result
//  output_query   out  1          echo of input_query
//  output_cnt     out  CNT_SIZE   min over rows (post-increment value in update mode)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Hash: row r uses p = {addr zero-extended to 32} * (32'h9E3779B1 ^ (r*32'h85EBCA6B)), mod 2^32; index = p[31 -: HASH_SIZE].
//  Storage: NUM_HASH RAMs, W x CNT_SIZE, 1-cycle read latency; read-during-write returns old data.
//  Pipeline: accept at cycle T -> hash reg T+1 -> RAM data and min/increment, write at T+2 -> output regs.
//   output_valid is asserted in cycle T+3. Latency is fixed at 3; throughput is 1 per cycle.
//  Forwarding: a read of (row,index) must see writes from up to 2 earlier accepted requests to the same (row,index).
//   Back-to-back same-address updates yield strictly consecutive counts.
//  Increment: new = (old == all-ones) ? old : old+1 per row (saturating); query mode writes nothing.
//  FSM: RUN, DRAIN, CLEAR.
//   RUN: input_ready = !clear_req (combinational). A clear_req moves to DRAIN; clear_req wins over a same-cycle input_valid.
//   DRAIN: input_ready=0; stay until the pipeline is empty; in-flight results are still emitted; then CLEAR.
//   CLEAR: idx counter 0..W-1 writes 0 to all rows, 1 index/cycle; exactly W cycles, then RUN.
//   clear_busy = (state != RUN). clear_req is ignored while in DRAIN or CLEAR.
//  Reset: state=CLEAR, idx=0, pipeline valids cleared. Outputs: input_ready=0, clear_busy=1, output_valid=0, output_addr/query/cnt=0.
//   Reset mid-operation drops in-flight requests (no output_valid) and restarts the sweep.
//  Output data regs hold their last value while output_valid=0.
// CONFIGURATION
//  CM_SKETCH_CONSERVATIVE_UPDATE_EN defined:
//   Update mode increments only the rows whose (forwarded) value equals the current min (saturating); other rows are rewritten unchanged.
//   output_cnt = min+1 (saturating).
//  Not defined: all NUM_HASH rows are incremented (classic CM sketch). Query mode is identical either way.
// TESTING (W=16, NUM_HASH=4, CNT_SIZE=32 unless noted)
//  1 Release rst -> clear_busy=1 for exactly 16 cycles, input_ready=0; then input_ready=1, clear_busy=0.
//  2 5 back-to-back updates addr 0x123 (accepted T..T+4) -> output_valid at T+3..T+7, output_cnt=1,2,3,4,5 (forwarding).
//  3 Then 2 queries addr 0x123 -> output_cnt=5,5, output_query=1; on a freshly cleared sketch, query 0x55 -> output_cnt=0.
//  4 CNT_SIZE=4, 20 updates addr 0x7 -> counts 1..15, then 15 for the remaining 5 (saturation).
//  5 clear_req 1 cycle after 2 accepted updates -> both results emitted; input_ready=0 same cycle; clear_busy for drain+16 cycles; query 0x123 -> 0.
//  6 Random 10k update/query mix vs golden model, run both with and without CM_SKETCH_CONSERVATIVE_UPDATE_EN.
//   Every output_cnt matches the model. Conservative estimates are never above classic ones and never below the true count.

Source files
------------

// File: rtl/cm_sketch_pipelined.sv
// Pipelined count-min sketch: hash -> RAM read -> min/saturating increment and write-back, with a clear sweep.
// Define CM_SKETCH_CONSERVATIVE_UPDATE_EN to increment only the rows holding the current minimum.
module cm_sketch_pipelined #(
  parameter int W         = 4096,
  parameter int NUM_HASH  = 4,
  parameter int ADDR_SIZE = 22,
  parameter int CNT_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_valid,
  input  logic [ADDR_SIZE-1:0] input_addr,
  input  logic                 input_query,
  output logic                 input_ready,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 output_valid,
  output logic [ADDR_SIZE-1:0] output_addr,
  output logic                 output_query,
  output logic [CNT_SIZE-1:0]  output_cnt
);
  localparam int HASH_SIZE = $clog2(W);
  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
  localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

  state_t                 state_reg;
  logic [HASH_SIZE-1:0]   clr_idx_reg;
  logic                   accept;

  logic [HASH_SIZE-1:0]   hash_idx     [NUM_HASH];
  logic                   s1_valid_reg;
  logic [ADDR_SIZE-1:0]   s1_addr_reg;
  logic                   s1_query_reg;
  logic [HASH_SIZE-1:0]   s1_idx_reg   [NUM_HASH];
  logic                   s2_valid_reg;
  logic [ADDR_SIZE-1:0]   s2_addr_reg;
  logic                   s2_query_reg;
  logic [HASH_SIZE-1:0]   s2_idx_reg   [NUM_HASH];
  logic [CNT_SIZE-1:0]    rd_data      [NUM_HASH];

  logic                   prev_we_reg;
  logic [HASH_SIZE-1:0]   prev_idx_reg [NUM_HASH];
  logic [CNT_SIZE-1:0]    prev_data_reg[NUM_HASH];

  logic [CNT_SIZE-1:0]    fwd          [NUM_HASH];
  logic [CNT_SIZE-1:0]    new_cnt      [NUM_HASH];
  logic [CNT_SIZE-1:0]    min_cnt;
  logic [CNT_SIZE-1:0]    result_cnt;
  logic                   we;
  logic [HASH_SIZE-1:0]   waddr        [NUM_HASH];
  logic [CNT_SIZE-1:0]    wdata        [NUM_HASH];

  assign input_ready = (state_reg == RUN) && !clear_req;
  assign clear_busy  = (state_reg != RUN);
  assign accept      = input_valid && input_ready;

  generate
    for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_row
      localparam logic [31:0] KEY = 32'h9E3779B1 ^ (32'(gi) * 32'h85EBCA6B);
      logic [CNT_SIZE-1:0] mem [W];
      logic [CNT_SIZE-1:0] rd_q;

      assign hash_idx[gi] = HASH_SIZE'((32'(input_addr) * KEY) >> (32 - HASH_SIZE));
      assign rd_data[gi]  = rd_q;

      always_ff @(posedge clk) begin
        if (we) mem[waddr[gi]] <= wdata[gi];
        rd_q <= mem[s1_idx_reg[gi]];
      end
    end
  endgenerate

  // The RAM read for a request lands in the same edge as the previous request's write,
  // so only the immediately preceding write has to be forwarded.
  always_comb begin
    min_cnt = CNT_MAX;
    for (int r = 0; r < NUM_HASH; r++) begin
      fwd[r] = (prev_we_reg && prev_idx_reg[r] == s2_idx_reg[r]) ? prev_data_reg[r] : rd_data[r];
      if (fwd[r] < min_cnt) min_cnt = fwd[r];
    end
    for (int r = 0; r < NUM_HASH; r++) begin
`ifdef CM_SKETCH_CONSERVATIVE_UPDATE_EN
      new_cnt[r] = (fwd[r] == min_cnt && fwd[r] != CNT_MAX) ? fwd[r] + CNT_ONE : fwd[r];
`else
      new_cnt[r] = (fwd[r] != CNT_MAX) ? fwd[r] + CNT_ONE : fwd[r];
`endif
    end
    result_cnt = (s2_query_reg || min_cnt == CNT_MAX) ? min_cnt : min_cnt + CNT_ONE;
  end

  always_comb begin
    we = 1'b0;
    for (int r = 0; r < NUM_HASH; r++) begin
      waddr[r] = s2_idx_reg[r];
      wdata[r] = new_cnt[r];
    end
    if (state_reg == CLEAR) begin
      we = 1'b1;
      for (int r = 0; r < NUM_HASH; r++) begin
        waddr[r] = clr_idx_reg;
        wdata[r] = '0;
      end
    end else if (s2_valid_reg && !s2_query_reg) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= CLEAR;
      clr_idx_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      prev_we_reg  <= 1'b0;
      output_valid <= 1'b0;
      output_addr  <= '0;
      output_query <= 1'b0;
      output_cnt   <= '0;
    end else begin
      unique case (state_reg)
        RUN:   if (clear_req) state_reg <= DRAIN;
        DRAIN: if (!s1_valid_reg && !s2_valid_reg) state_reg <= CLEAR;
        CLEAR: begin
          clr_idx_reg <= clr_idx_reg + 1'b1;
          if (&clr_idx_reg) state_reg <= RUN;
        end
        default: state_reg <= CLEAR;
      endcase

      s1_valid_reg  <= accept;
      s1_addr_reg   <= input_addr;
      s1_query_reg  <= input_query;
      s1_idx_reg    <= hash_idx;
      s2_valid_reg  <= s1_valid_reg;
      s2_addr_reg   <= s1_addr_reg;
      s2_query_reg  <= s1_query_reg;
      s2_idx_reg    <= s1_idx_reg;
      prev_we_reg   <= we;
      prev_idx_reg  <= waddr;
      prev_data_reg <= wdata;

      output_valid <= s2_valid_reg;
      if (s2_valid_reg) begin
        output_addr  <= s2_addr_reg;
        output_query <= s2_query_reg;
        output_cnt   <= result_cnt;
      end
    end
  end
endmodule
